fetch_bundle_queue: RTL and testbench

// - Decoupling FIFO between FetchStage1 and FetchStage2. Captures each fetched 4-wide bundle with its
//   PC and per-slot BTB hit / direction prediction / target address.
// - Holds up to DEPTH bundles, so an FS2/decode stall does not freeze the I-cache pipe.
// - Drives FetchStage1's stall input and presents the oldest bundle to FetchStage2 with a valid/ready handshake.

---
 rtl/fetch_bundle_queue.sv | 119 +++++++++++
 tb/tb_fetch_bundle_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO between FetchStage1 and FetchStage2 holding fetched bundles with per-slot prediction info.
// Optional same-cycle bypass when empty is enabled by defining FETCHQ_BYPASS_EN.
module fetch_bundle_queue #(
    parameter int PC_W   = 32,
    parameter int INST_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      enqValid_i,
    input  logic [PC_W-1:0]           pc_i,
    input  logic [4*INST_W-1:0]       bundle_i,
    input  logic [3:0]                btbHit_i,
    input  logic [3:0]                prediction_i,
    input  logic [4*PC_W-1:0]         target_i,
    output logic                      stall_o,
    output logic                      deqValid_o,
    input  logic                      deqReady_i,
    output logic [PC_W-1:0]           pc_o,
    output logic [4*INST_W-1:0]       bundle_o,
    output logic [3:0]                btbHit_o,
    output logic [3:0]                prediction_o,
    output logic [4*PC_W-1:0]         target_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          CNT_W   = PTR_W + 1;
    localparam int unsigned DEPTH_U = DEPTH;

    logic [PC_W-1:0]     pc_mem     [DEPTH];
    logic [4*INST_W-1:0] bundle_mem [DEPTH];
    logic [3:0]          btb_mem    [DEPTH];
    logic [3:0]          pred_mem   [DEPTH];
    logic [4*PC_W-1:0]   tgt_mem    [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic empty;
    logic bypass;
    logic bypass_take;
    logic enq_fire;
    logic deq_fire;
    logic do_write;
    logic do_pop;

    assign empty   = (count == '0);
    assign stall_o = (count == CNT_W'(DEPTH));
    assign count_o = count;

    always_comb begin
        bypass = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        bypass = empty & enqValid_i & ~flush_i;
`endif
    end

    assign deqValid_o  = ~empty | bypass;
    assign enq_fire    = enqValid_i & ~stall_o & ~flush_i;
    assign deq_fire    = deqValid_o & deqReady_i & ~flush_i;
    // A bypassed bundle consumed in the same cycle never touches storage or pointers.
    assign bypass_take = bypass & deqReady_i;
    assign do_write    = enq_fire & ~bypass_take;
    assign do_pop      = deq_fire & ~bypass_take;

    always_comb begin
        pc_o         = pc_mem[head];
        bundle_o     = bundle_mem[head];
        btbHit_o     = btb_mem[head];
        prediction_o = pred_mem[head];
        target_o     = tgt_mem[head];
        if (bypass) begin
            pc_o         = pc_i;
            bundle_o     = bundle_i;
            btbHit_o     = btbHit_i;
            prediction_o = prediction_i;
            target_o     = target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                pc_mem[i]     <= '0;
                bundle_mem[i] <= '0;
                btb_mem[i]    <= '0;
                pred_mem[i]   <= '0;
                tgt_mem[i]    <= '0;
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_write) begin
                pc_mem[tail]     <= pc_i;
                bundle_mem[tail] <= bundle_i;
                btb_mem[tail]    <= btbHit_i;
                pred_mem[tail]   <= prediction_i;
                tgt_mem[tail]    <= target_i;
                tail             <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Scoreboard bench for fetch_bundle_queue: expected bundles are queued when enqueued and compared on dequeue.
// Also exercises the FETCHQ_BYPASS_EN build when that macro is defined.
module tb_fetch_bundle_queue;
    localparam int PC_W   = 32;
    localparam int INST_W = 64;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [PC_W-1:0]     pc;
        logic [4*INST_W-1:0] bundle;
        logic [3:0]          btb;
        logic [3:0]          pred;
        logic [4*PC_W-1:0]   tgt;
    } ent_t;

    logic                   clk;
    logic                   reset;
    logic                   flush_i;
    logic                   enqValid_i;
    logic [PC_W-1:0]        pc_i;
    logic [4*INST_W-1:0]    bundle_i;
    logic [3:0]             btbHit_i;
    logic [3:0]             prediction_i;
    logic [4*PC_W-1:0]      target_i;
    logic                   stall_o;
    logic                   deqValid_o;
    logic                   deqReady_i;
    logic [PC_W-1:0]        pc_o;
    logic [4*INST_W-1:0]    bundle_o;
    logic [3:0]             btbHit_o;
    logic [3:0]             prediction_o;
    logic [4*PC_W-1:0]      target_o;
    logic [$clog2(DEPTH):0] count_o;

    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_bundle_queue #(
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .enqValid_i   (enqValid_i),
        .pc_i         (pc_i),
        .bundle_i     (bundle_i),
        .btbHit_i     (btbHit_i),
        .prediction_i (prediction_i),
        .target_i     (target_i),
        .stall_o      (stall_o),
        .deqValid_o   (deqValid_o),
        .deqReady_i   (deqReady_i),
        .pc_o         (pc_o),
        .bundle_o     (bundle_o),
        .btbHit_o     (btbHit_o),
        .prediction_o (prediction_o),
        .target_o     (target_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4*INST_W-1:0] mk_bundle(input logic [PC_W-1:0] pc);
        logic [4*INST_W-1:0] b;
        for (int i = 0; i < 4; i++) b[i*INST_W +: INST_W] = {pc ^ 32'hCAFE_0000, pc + 32'(i)};
        return b;
    endfunction

    function automatic logic [4*PC_W-1:0] mk_tgt(input logic [PC_W-1:0] pc);
        logic [4*PC_W-1:0] t;
        for (int i = 0; i < 4; i++) t[i*PC_W +: PC_W] = pc + 32'h1000 * 32'(i + 1);
        return t;
    endfunction

    task automatic check_head(input string tag, input ent_t e);
        check_eq({tag, "_pc"},     pc_o,         e.pc);
        check_eq({tag, "_bundle"}, bundle_o,     e.bundle);
        check_eq({tag, "_btb"},    btbHit_o,     e.btb);
        check_eq({tag, "_pred"},   prediction_o, e.pred);
        check_eq({tag, "_target"}, target_o,     e.tgt);
    endtask

    // One clock cycle: drive, check at the falling edge, update the scoreboard, advance.
    task automatic cycle(input logic enq, input logic deq, input logic flush,
                         input logic [PC_W-1:0] pc, input logic [3:0] btb,
                         input logic [3:0] pred, input logic [4*PC_W-1:0] tgt);
        ent_t e;
        bit   byp;
        bit   enq_fire;
        bit   deq_fire;
        int   sz;
        enqValid_i   = enq;
        deqReady_i   = deq;
        flush_i      = flush;
        pc_i         = pc;
        bundle_i     = mk_bundle(pc);
        btbHit_i     = btb;
        prediction_i = pred;
        target_i     = tgt;
        @(negedge clk);
        sz  = sb.size();
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (sz == 0) && enq && !flush;
`endif
        check_eq("count", count_o, sz);
        check_eq("stall", stall_o, sz == DEPTH);
        check_eq("deq_valid", deqValid_o, (sz != 0) || byp);
        e        = '{pc, mk_bundle(pc), btb, pred, tgt};
        enq_fire = enq && (sz != DEPTH) && !flush;
        deq_fire = deq && ((sz != 0) || byp) && !flush;
        if (deq_fire) begin
            if (byp) check_head("bypass", e);
            else begin
                check_head("head", sb[0]);
                void'(sb.pop_front());
            end
        end
        if (flush) sb.delete();
        else if (enq_fire && !(byp && deq_fire)) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic enq_only(input logic [PC_W-1:0] pc);
        cycle(1'b1, 1'b0, 1'b0, pc, 4'b0001, 4'b0001, mk_tgt(pc));
    endtask

    task automatic deq_only();
        cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [4*PC_W-1:0] t;
        logic [PC_W-1:0]   pc;
        reset = 1'b1; flush_i = 1'b0; enqValid_i = 1'b0; deqReady_i = 1'b0;
        pc_i = '0; bundle_i = '0; btbHit_i = '0; prediction_i = '0; target_i = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_valid", deqValid_o, 0);
        check_eq("rst_pc", pc_o, 0);
        check_eq("rst_bundle", bundle_o, 0);
        check_eq("rst_target", target_o, 0);
        @(posedge clk);
        #1;

        // Single enqueue then dequeue (latency and count via the next cycle's checks).
        enq_only(32'h100);
        deq_only();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);

        // Fill, refused fifth, full with simultaneous deq, refill, drain.
        for (int i = 0; i < 4; i++) enq_only(32'h100 + 32'(i) * 32'h20);
        enq_only(32'h180);
        cycle(1'b1, 1'b1, 1'b0, 32'h180, 4'b0010, 4'b0000, mk_tgt(32'h180));
        enq_only(32'h180);
        for (int i = 0; i < 5; i++) deq_only();

        // Steady streaming across pointer wrap, with varied per-slot fields.
        pc = 32'h1000;
        for (int i = 0; i < 10; i++) begin
            t = mk_tgt(pc);
            if (i == 3) t[2*PC_W +: PC_W] = 32'h400;
            cycle(1'b1, 1'b1, 1'b0, pc, (i == 3) ? 4'b0100 : 4'(i), 4'(i * 3), t);
            pc = pc + 32'h20;
        end
        deq_only();

        // Flush with a concurrent enqueue; the flushed-cycle bundle must never appear.
        for (int i = 0; i < 3; i++) enq_only(32'h2000 + 32'(i) * 32'h20);
        cycle(1'b1, 1'b1, 1'b1, 32'h2BAD, 4'b1111, 4'b1111, mk_tgt(32'h2BAD));
        enq_only(32'h3000);
        deq_only();
        deq_only();

`ifdef FETCHQ_BYPASS_EN
        cycle(1'b1, 1'b1, 1'b0, 32'h200, 4'b1000, 4'b1000, mk_tgt(32'h200));
        cycle(1'b1, 1'b0, 1'b0, 32'h220, 4'b0000, 4'b0000, mk_tgt(32'h220));
        deq_only();
`endif

        // Reset mid-operation overrides enqueue, dequeue and flush.
        enq_only(32'h4000);
        enq_only(32'h4020);
        reset = 1'b1; enqValid_i = 1'b1; deqReady_i = 1'b1; flush_i = 1'b1; pc_i = 32'h4040;
        @(posedge clk);
        #1;
        reset = 1'b0; enqValid_i = 1'b0; deqReady_i = 1'b0; flush_i = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_count", count_o, 0);
        check_eq("midrst_valid", deqValid_o, 0);
        check_eq("midrst_pc", pc_o, 0);
        @(posedge clk);
        #1;
        enq_only(32'h5000);
        deq_only();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
